// File: rtl/wb_regfile.sv
// wb_regfile: RISC-V write-back stage and 32x32 integer register file.
// Selects the write-back value (ALU result or load data) and commits it.
// x0 is hardwired to zero. Both decode read ports bypass the value being
// written in the same cycle. Also counts the number of committed writes.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  mem_data_in,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] wb_count
);

  logic [XLEN-1:0]  r_regs [32];
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  w_data;
  logic             w_valid;

  // Write-back select and qualification; writes to x0 or during reset are dropped
  always_comb begin
    w_data  = mem_to_reg_in ? mem_data_in : alu_result_in;
    w_valid = reg_write_in && (rd_in != 5'd0) && !rst;
  end

  // Read port 1: x0 reads zero, otherwise bypass the current write, else storage
  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == 5'd0)
      rs1_data = '0;
    else if (w_valid && (rs1_addr == rd_in))
      rs1_data = w_data;
  end

  // Read port 2: same rules as port 1, fully independent
  always_comb begin
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == 5'd0)
      rs2_data = '0;
    else if (w_valid && (rs2_addr == rd_in))
      rs2_data = w_data;
  end

  // Register commit and retired-write counter (wraps silently)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs  <= '{default: '0};
      r_count <= '0;
    end else if (w_valid) begin
      r_regs[rd_in] <= w_data;
      r_count       <= r_count + CNT_W'(1);
    end
  end

  assign wb_valid = w_valid;
  assign wb_rd    = rd_in;
  assign wb_data  = w_data;
  assign wb_count = r_count;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and integer register file for the 5-stage RISC-V pipeline. Consumes the registered MEM/WB pipeline outputs and selects the write-back value (ALU result or load data). Commits that value into a 32×32 register file with x0 hardwired to zero, and serves the two decode-stage read ports with same-cycle write-through bypass. Also exports the write-back bus to the EX forwarding unit and keeps a retired-write counter.

## Interface
- `XLEN`, 32, data width of registers and write-back bus
- `CNT_W`, 32, width of the retired-write counter

- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `alu_result_in`  in  XLEN  ALU result from MEM/WB register
- `mem_data_in`  in  XLEN  load data from MEM/WB register
- `rd_in`  in  5  destination register index
- `reg_write_in`  in  1  write-back enable
- `mem_to_reg_in`  in  1  1 = write load data, 0 = write ALU result
- `rs1_addr`, `rs2_addr`  in  5 each  decode-stage read addresses
- `rs1_data`, `rs2_data`  out  XLEN each  read data, combinational
- `wb_valid`  out  1  a real register write occurs this cycle (forwarding)
- `wb_rd`  out  5  destination index of the current write-back
- `wb_data`  out  XLEN  selected write-back value
- `wb_count`  out  CNT_W  number of committed writes since reset

## Operation
- Write-back select:
  - `wb_data = mem_to_reg_in ? mem_data_in : alu_result_in`, combinational.
  - `wb_rd = rd_in`.
- Write qualification: `wb_valid = reg_write_in && (rd_in != 0) && !rst`.
- Commit: on a rising edge with `wb_valid`, `regs[rd_in] <= wb_data`. No other entry changes.
- x0:
  - Never written; `regs[0]` stays 0 permanently.
  - Any read of address 0 returns 0, including when `rd_in == 0` with `reg_write_in = 1`.
  - A write to x0 is dropped and not counted.
- Read port N (N = 1, 2):
  - If `rsN_addr == 0`, return 0.
  - Else if `wb_valid && rsN_addr == rd_in`, return `wb_data` (write-through bypass).
  - Else return `regs[rsN_addr]`.
- Both read ports are independent. The same address on both ports is legal and gives identical data.
- Counter:
  - On a rising edge with `wb_valid`, `wb_count <= wb_count + 1`, modulo 2^CNT_W.
  - Wrap from all-ones to 0 is silent; no saturation and no flag.
- Reset:
  - A rising edge with `rst = 1` clears all 32 registers and `wb_count` to 0.
  - Any write presented in that cycle is discarded, because `wb_valid` is forced low.
- No stall or flush inputs. Bubbles arrive as `reg_write_in = 0` from the upstream register, which resets its own control bits.

## Timing
- Write latency: 1 cycle. The value is visible from storage on the cycle after the commit edge, and through the bypass in the same cycle.
- Read latency: 0 cycles (combinational from address and write-back inputs).
- The `wb_valid`, `wb_rd` and `wb_data` outputs are combinational from the current inputs, with no added register stage.
- Values during and immediately after reset:
  - While `rst = 1`: `wb_valid = 0`, and read ports return stored values (0 once the first reset edge has occurred).
  - After the first reset edge: `wb_count = 0` and all registers are 0.
- Reset mid-stream: a write presented in the same cycle as `rst` is lost. The first write counted after release is the one presented on the first cycle with `rst = 0`.
- Back-to-back writes to the same `rd`: each cycle's value commits in order, and the bypass always reflects the current cycle's value.

## Test plan
- Reset, then read all 32 addresses on both ports -> every `rsN_data = 0`, `wb_count = 0`.
- Present `rd_in = 5`, `reg_write_in = 1`, `mem_to_reg_in = 0`, `alu_result_in = 0x1234_5678`, `rs1_addr = 5` in the same cycle -> `rs1_data = 0x1234_5678` (bypass) and `wb_valid = 1`. Next cycle with `reg_write_in = 0` -> still `0x1234_5678` (storage), `wb_count = 1`.
- Present `mem_to_reg_in = 1`, `mem_data_in = 0xDEAD_BEEF`, `alu_result_in = 0x1`, `rd_in = 31` -> `wb_data = 0xDEAD_BEEF`; `regs[31]` reads `0xDEAD_BEEF` afterwards.
- Present a write to x0 with data `0xFFFF_FFFF`, with `rs1_addr = rs2_addr = 0` -> both reads 0, `wb_valid = 0`, `wb_count` unchanged.
- Write `rd = 7` with `0xAA` while asserting `rst` in the same cycle -> after the edge, `regs[7] = 0` and `wb_count = 0`.
- Build with `CNT_W = 4` and perform 17 valid writes -> `wb_count = 1` (wrap).
